// File: rtl/wb_slot_scheduler.sv
// Writeback-slot scheduler for a single regfile write port fed by fixed-latency units.
// Tracks reservations in a shift line and gates issue on slot, RAW and WAW hazards.
module wb_slot_scheduler #(
  parameter int unsigned MAX_LAT = 4,
  parameter int unsigned RW      = 5,
  parameter int unsigned LATW    = $clog2(MAX_LAT + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic [RW-1:0]   issue_rs,
  input  logic [RW-1:0]   issue_rt,
  input  logic [RW-1:0]   issue_rd,
  input  logic            issue_wben,
  input  logic [LATW-1:0] issue_lat,
  output logic            issue_ready,
  output logic            lat_err,
  output logic            wb_valid,
  output logic [RW-1:0]   wb_rd,
  output logic [LATW-1:0] pending,
  output logic [31:0]     stall_cnt
);

  logic [MAX_LAT:1] res_v_q, res_v_d;
  logic [RW-1:0]    res_rd_q [MAX_LAT:1];
  logic [RW-1:0]    res_rd_d [MAX_LAT:1];
  logic [LATW-1:0]  pending_q, pending_d;
  logic [31:0]      stall_cnt_q, stall_cnt_d;

  logic        lat_bad;
  logic        need_res;
  logic        busy_rs, busy_rt, busy_rd;
  logic        slot_taken;
  logic        fire;
  logic        res_add;
  int unsigned lat_u;

  // Hazard detection is independent of issue_valid so decode can precompute readiness.
  always_comb begin
    lat_u      = 32'(issue_lat);
    lat_bad    = (lat_u == 0) || (lat_u > MAX_LAT);
    need_res   = issue_wben && (issue_rd != '0);
    busy_rs    = 1'b0;
    busy_rt    = 1'b0;
    busy_rd    = 1'b0;
    slot_taken = 1'b0;
    for (int unsigned k = 1; k <= MAX_LAT; k++) begin
      if (res_v_q[k]) begin
        if ((issue_rs != '0) && (res_rd_q[k] == issue_rs)) busy_rs = 1'b1;
        if ((issue_rt != '0) && (res_rd_q[k] == issue_rt)) busy_rt = 1'b1;
        if ((issue_rd != '0) && (res_rd_q[k] == issue_rd)) busy_rd = 1'b1;
        if (k == lat_u + 1) slot_taken = 1'b1;
      end
    end
    issue_ready = !lat_bad && !busy_rs && !busy_rt
                  && !(need_res && busy_rd) && !(need_res && slot_taken);
    lat_err     = issue_valid && lat_bad;
    fire        = issue_valid && issue_ready;
    res_add     = fire && need_res;
  end

  always_comb begin
    res_v_d  = '0;
    res_rd_d = res_rd_q;
    for (int unsigned k = 1; k < MAX_LAT; k++) begin
      res_v_d[k]  = res_v_q[k+1];
      res_rd_d[k] = res_rd_q[k+1];
    end
    res_rd_d[MAX_LAT] = '0;
    // The slot check guarantees the shifted-in entry at issue_lat is empty.
    if (res_add) begin
      for (int unsigned k = 1; k <= MAX_LAT; k++) begin
        if (k == lat_u) begin
          res_v_d[k]  = 1'b1;
          res_rd_d[k] = issue_rd;
        end
      end
    end

    pending_d = pending_q;
    if (res_add && !res_v_q[1]) pending_d = pending_q + LATW'(1);
    else if (!res_add && res_v_q[1]) pending_d = pending_q - LATW'(1);

    stall_cnt_d = stall_cnt_q;
    if (issue_valid && !issue_ready && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_v_q     <= '0;
      pending_q   <= '0;
      stall_cnt_q <= '0;
      for (int unsigned k = 1; k <= MAX_LAT; k++) res_rd_q[k] <= '0;
    end else begin
      res_v_q     <= res_v_d;
      res_rd_q    <= res_rd_d;
      pending_q   <= pending_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign wb_valid  = res_v_q[1];
  assign wb_rd     = res_v_q[1] ? res_rd_q[1] : '0;
  assign pending   = pending_q;
  assign stall_cnt = stall_cnt_q;

endmodule
